// File: rtl/i2c_apb_txn_sequencer_if.sv
// Request, byte-stream and APB-master signals of the I2C transaction sequencer.
// The master modport is the sequencer's view; the slave modport is the requester / APB slave side.
interface i2c_apb_txn_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [6:0] req_addr_i;
  logic       req_rw_i;
  logic [7:0] req_len_i;
  logic [7:0] req_prescaler_i;

  logic       wdata_valid_i;
  logic [7:0] wdata_i;
  logic       wdata_ready_o;

  logic       rdata_valid_o;
  logic [7:0] rdata_o;
  logic       rdata_ready_i;

  logic       busy_o;
  logic       done_o;
  logic       error_o;

  logic       m_psel_o;
  logic       m_penable_o;
  logic       m_pwrite_o;
  logic [7:0] m_paddr_o;
  logic [7:0] m_pwdata_o;
  logic [7:0] m_prdata_i;
  logic       m_pready_i;

  modport master (
    input  req_valid_i, req_addr_i, req_rw_i, req_len_i, req_prescaler_i,
    input  wdata_valid_i, wdata_i, rdata_ready_i,
    input  m_prdata_i, m_pready_i,
    output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
    output busy_o, done_o, error_o,
    output m_psel_o, m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_rw_i, req_len_i, req_prescaler_i,
    output wdata_valid_i, wdata_i, rdata_ready_i,
    output m_prdata_i, m_pready_i,
    input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
    input  busy_o, done_o, error_o,
    input  m_psel_o, m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o
  );
endinterface

// File: rtl/i2c_apb_txn_sequencer.sv
// Runs one I2C transaction on i2c_master_top through its APB port; >=3 cycles per APB transfer.
// Backpressure: write bytes wait on wdata_valid_i, reads stall while rdata_valid_o is unaccepted.
module i2c_apb_txn_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_POLLS  = 1024,
  parameter logic [7:0]  ADDR_PRESCALER = 8'h00,
  parameter logic [7:0]  ADDR_CMD       = 8'h01,
  parameter logic [7:0]  ADDR_TRANSMIT  = 8'h02,
  parameter logic [7:0]  ADDR_RECEIVE   = 8'h03,
  parameter logic [7:0]  ADDR_ADDR_RW   = 8'h04,
  parameter logic [7:0]  ADDR_STATUS    = 8'h05,
  parameter int unsigned TX_EMPTY_BIT   = 5,
  parameter int unsigned RX_AVAIL_BIT   = 3
) (
  input  logic                     pclk_i,
  input  logic                     preset_i,
  i2c_apb_txn_sequencer_if.master  bus
);

  localparam int unsigned   PW         = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(TIMEOUT_POLLS - 1);
  localparam logic [7:0]    MAX_WR_LEN = 8'(FIFO_DEPTH);
  localparam logic [7:0]    CMD_OFF    = 8'h00;
  localparam logic [7:0]    CMD_RUN    = 8'h60;
  localparam logic [7:0]    CMD_IDLE   = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_RST, S_CFG_PRE, S_CFG_ADR, S_PUSH, S_GO, S_POLL_TX,
    S_POLL_RX, S_RD, S_RD_OUT, S_CLOSE, S_ABORT, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] len;
    logic [7:0] prescaler;
  } req_t;

  state_t        state_q, state_d;
  phase_t        phase_q;
  req_t          req_q;
  logic [7:0]    paddr_q, pwdata_q, rdata_q, cnt_q;
  logic          pwrite_q, err_q;
  logic [PW-1:0] poll_q;

  logic          xfer_want, xfer_write, xfer_done;
  logic [7:0]    xfer_addr, xfer_data;
  logic          req_take, req_bad, cnt_inc, poll_inc, poll_clr, err_set, rdata_ld;

  assign xfer_done = (phase_q == PH_ACCESS) && bus.m_pready_i;
  assign req_bad   = (bus.req_len_i == 8'd0) ||
                     (!bus.req_rw_i && (bus.req_len_i > MAX_WR_LEN));

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    xfer_want  = 1'b0;
    xfer_write = 1'b1;
    xfer_addr  = ADDR_CMD;
    xfer_data  = 8'h00;
    req_take   = 1'b0;
    cnt_inc    = 1'b0;
    poll_inc   = 1'b0;
    poll_clr   = 1'b0;
    err_set    = 1'b0;
    rdata_ld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          req_take = 1'b1;
          state_d  = req_bad ? S_DONE : S_CFG_RST;
        end
      end
      S_CFG_RST: begin
        xfer_want = 1'b1;
        xfer_data = CMD_OFF;
        if (xfer_done) state_d = S_CFG_PRE;
      end
      S_CFG_PRE: begin
        xfer_want = 1'b1;
        xfer_addr = ADDR_PRESCALER;
        xfer_data = req_q.prescaler;
        if (xfer_done) state_d = S_CFG_ADR;
      end
      S_CFG_ADR: begin
        xfer_want = 1'b1;
        xfer_addr = ADDR_ADDR_RW;
        xfer_data = {req_q.addr, req_q.rw};
        if (xfer_done) state_d = req_q.rw ? S_GO : S_PUSH;
      end
      S_PUSH: begin
        // A byte transfer only starts once the source has a byte; it is consumed at completion.
        xfer_want = bus.wdata_valid_i;
        xfer_addr = ADDR_TRANSMIT;
        xfer_data = bus.wdata_i;
        if (xfer_done) begin
          cnt_inc = 1'b1;
          if ((cnt_q + 8'd1) == req_q.len) state_d = S_GO;
        end
      end
      S_GO: begin
        xfer_want = 1'b1;
        xfer_data = CMD_RUN;
        if (xfer_done) state_d = req_q.rw ? S_POLL_RX : S_POLL_TX;
      end
      S_POLL_TX, S_POLL_RX: begin
        xfer_want  = 1'b1;
        xfer_write = 1'b0;
        xfer_addr  = ADDR_STATUS;
        if (xfer_done) begin
          if ((state_q == S_POLL_TX) ? bus.m_prdata_i[TX_EMPTY_BIT]
                                     : bus.m_prdata_i[RX_AVAIL_BIT]) begin
            poll_clr = 1'b1;
            state_d  = (state_q == S_POLL_TX) ? S_CLOSE : S_RD;
          end else if (poll_q == POLL_LAST) begin
            poll_clr = 1'b1;
            err_set  = 1'b1;
            state_d  = S_ABORT;
          end else begin
            poll_inc = 1'b1;
          end
        end
      end
      S_RD: begin
        xfer_want  = 1'b1;
        xfer_write = 1'b0;
        xfer_addr  = ADDR_RECEIVE;
        if (xfer_done) begin
          rdata_ld = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (bus.rdata_ready_i) state_d = (cnt_q == req_q.len) ? S_CLOSE : S_POLL_RX;
      end
      S_CLOSE: begin
        xfer_want = 1'b1;
        xfer_data = CMD_IDLE;
        if (xfer_done) state_d = S_DONE;
      end
      S_ABORT: begin
        xfer_want = 1'b1;
        xfer_data = CMD_OFF;
        if (xfer_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Entering PH_SETUP only from PH_IDLE guarantees one idle cycle between transfers.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      phase_q  <= PH_IDLE;
      paddr_q  <= 8'h00;
      pwdata_q <= 8'h00;
      pwrite_q <= 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (xfer_want) begin
            phase_q  <= PH_SETUP;
            paddr_q  <= xfer_addr;
            pwdata_q <= xfer_write ? xfer_data : 8'h00;
            pwrite_q <= xfer_write;
          end
        end
        PH_SETUP:  phase_q <= PH_ACCESS;
        PH_ACCESS: if (bus.m_pready_i) phase_q <= PH_IDLE;
        default:   phase_q <= PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      req_q   <= '0;
      cnt_q   <= 8'h00;
      poll_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      if (req_take) begin
        req_q  <= '{addr: bus.req_addr_i, rw: bus.req_rw_i,
                    len: bus.req_len_i, prescaler: bus.req_prescaler_i};
        cnt_q  <= 8'h00;
        poll_q <= '0;
        err_q  <= req_bad;
      end else begin
        if (cnt_inc)  cnt_q  <= cnt_q + 8'd1;
        if (poll_clr) poll_q <= '0;
        else if (poll_inc) poll_q <= poll_q + 1'b1;
        if (err_set)  err_q  <= 1'b1;
      end
      if (rdata_ld) rdata_q <= bus.m_prdata_i;
    end
  end

  assign bus.req_ready_o   = (state_q == S_IDLE);
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.error_o       = (state_q == S_DONE) && err_q;
  assign bus.wdata_ready_o = (state_q == S_PUSH) && xfer_done;
  assign bus.rdata_valid_o = (state_q == S_RD_OUT);
  assign bus.rdata_o       = rdata_q;
  assign bus.m_psel_o      = (phase_q != PH_IDLE);
  assign bus.m_penable_o   = (phase_q == PH_ACCESS);
  assign bus.m_pwrite_o    = pwrite_q;
  assign bus.m_paddr_o     = paddr_q;
  assign bus.m_pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_i2c_apb_txn_sequencer.sv
// Directed bench: an APB slave model logs completed transfers, which are compared
// against hand-computed tables; multi-cycle corners are hand-written sequences.
module tb_i2c_apb_txn_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_apb_txn_sequencer_if bus();

  i2c_apb_txn_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_POLLS(4)) dut (
    .pclk_i  (clk),
    .preset_i(rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave model and transfer log
  logic [7:0] status_val = 8'h00;
  int         wait_cfg   = 0;
  int         acc_cnt    = 0;
  logic [7:0] rx_mem [0:7];
  int         rx_idx     = 0;
  logic       log_w [0:255];
  logic [7:0] log_a [0:255];
  logic [7:0] log_d [0:255];
  int         log_n     = 0;
  int         stab_err  = 0;
  int         stall_err = 0;
  int         psel_cnt  = 0;
  int         pen_cnt   = 0;
  logic [7:0] s_addr, s_data;
  logic       s_w;

  always_comb begin
    bus.m_pready_i = (wait_cfg == 0) ? 1'b1 : (bus.m_penable_o && (acc_cnt == wait_cfg));
    bus.m_prdata_i = 8'hEE;
    if (bus.m_paddr_o == 8'h05) bus.m_prdata_i = status_val;
    else if (bus.m_paddr_o == 8'h03) bus.m_prdata_i = rx_mem[rx_idx[2:0]];
  end

  always @(posedge clk) begin
    if (bus.m_psel_o) psel_cnt <= psel_cnt + 1;
    if (bus.m_penable_o) pen_cnt <= pen_cnt + 1;
    if (bus.m_psel_o && bus.rdata_valid_o) stall_err <= stall_err + 1;
    if (bus.m_psel_o && !bus.m_penable_o) begin
      s_addr <= bus.m_paddr_o;
      s_data <= bus.m_pwdata_o;
      s_w    <= bus.m_pwrite_o;
    end
    if (bus.m_psel_o && bus.m_penable_o) begin
      if (bus.m_paddr_o !== s_addr || bus.m_pwdata_o !== s_data || bus.m_pwrite_o !== s_w)
        stab_err <= stab_err + 1;
      if (bus.m_pready_i) begin
        log_w[log_n[7:0]] <= bus.m_pwrite_o;
        log_a[log_n[7:0]] <= bus.m_paddr_o;
        log_d[log_n[7:0]] <= bus.m_pwrite_o ? bus.m_pwdata_o : bus.m_prdata_i;
        log_n   <= log_n + 1;
        acc_cnt <= 0;
        if (!bus.m_pwrite_o && bus.m_paddr_o == 8'h03) rx_idx <= rx_idx + 1;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } apb_vec_t;

  typedef struct {
    logic       rw;
    logic [7:0] len;
    logic       exp_done;
    logic       exp_err;
  } rej_vec_t;

  apb_vec_t wr_tab [0:7];
  rej_vec_t rej_tab [0:2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic rw, input logic [6:0] addr, input logic [7:0] len,
                          input logic [7:0] presc);
    bus.req_rw_i        = rw;
    bus.req_addr_i      = addr;
    bus.req_len_i       = len;
    bus.req_prescaler_i = presc;
    bus.req_valid_i     = 1'b1;
    tick();
    bus.req_valid_i     = 1'b0;
  endtask

  task automatic feed_bytes(input int n, input logic [7:0] first);
    for (int b = 0; b < n; b++) begin
      int t;
      bus.wdata_valid_i = 1'b1;
      bus.wdata_i       = first + 8'(b);
      t = 0;
      while (!bus.wdata_ready_o && t < 300) begin
        tick();
        t++;
      end
      if (t >= 300) begin
        chk("wdata_ready_timeout", 0, 1);
        break;
      end
      tick();
    end
    bus.wdata_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!bus.done_o && t < 500) begin
      tick();
      t++;
    end
    chk({name, "_done"}, int'(bus.done_o), 1);
  endtask

  task automatic run_write_trace(input string name);
    int base, pen0;
    base = log_n;
    pen0 = pen_cnt;
    send_req(1'b0, 7'h50, 8'd2, 8'd4);
    feed_bytes(2, 8'hB0);
    wait_done(name);
    chk({name, "_err"}, int'(bus.error_o), 0);
    tick();
    chk({name, "_pen_cycles"}, pen_cnt - pen0, 8 * (wait_cfg + 1));
    chk({name, "_count"}, log_n - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_w%0d", name, i), int'(log_w[base + i]), int'(wr_tab[i].w));
      chk($sformatf("%s_a%0d", name, i), int'(log_a[base + i]), int'(wr_tab[i].a));
      chk($sformatf("%s_d%0d", name, i), int'(log_d[base + i]), int'(wr_tab[i].d));
    end
  endtask

  initial begin
    int base, nstat, nrecv;

    wr_tab[0] = '{1'b1, 8'h01, 8'h00};
    wr_tab[1] = '{1'b1, 8'h00, 8'h04};
    wr_tab[2] = '{1'b1, 8'h04, 8'hA0};
    wr_tab[3] = '{1'b1, 8'h02, 8'hB0};
    wr_tab[4] = '{1'b1, 8'h02, 8'hB1};
    wr_tab[5] = '{1'b1, 8'h01, 8'h60};
    wr_tab[6] = '{1'b0, 8'h05, 8'h20};
    wr_tab[7] = '{1'b1, 8'h01, 8'h20};
    rej_tab[0] = '{1'b0, 8'd9, 1'b1, 1'b1};
    rej_tab[1] = '{1'b0, 8'd0, 1'b1, 1'b1};
    rej_tab[2] = '{1'b1, 8'd0, 1'b1, 1'b1};
    rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; rx_mem[2] = 8'h33; rx_mem[3] = 8'h44;
    rx_mem[4] = 8'h55; rx_mem[5] = 8'h66; rx_mem[6] = 8'h77; rx_mem[7] = 8'h88;

    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_rw_i = 1'b0;
    bus.req_len_i = '0; bus.req_prescaler_i = '0;
    bus.wdata_valid_i = 1'b0; bus.wdata_i = '0; bus.rdata_ready_i = 1'b0;

    tick();
    tick();
    chk("rst_req_ready", int'(bus.req_ready_o), 1);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_error", int'(bus.error_o), 0);
    chk("rst_psel", int'(bus.m_psel_o), 0);
    chk("rst_penable", int'(bus.m_penable_o), 0);
    chk("rst_rvalid", int'(bus.rdata_valid_o), 0);
    chk("rst_wready", int'(bus.wdata_ready_o), 0);
    rst = 1'b0;
    tick();

    // Write len=2, zero wait states
    status_val = 8'h20;
    run_write_trace("wr0");

    // Rejected requests: done/error one cycle after acceptance, no APB activity
    for (int i = 0; i < 3; i++) begin
      base = psel_cnt;
      send_req(rej_tab[i].rw, 7'h11, rej_tab[i].len, 8'd1);
      chk($sformatf("rej%0d_done", i), int'(bus.done_o), int'(rej_tab[i].exp_done));
      chk($sformatf("rej%0d_err", i), int'(bus.error_o), int'(rej_tab[i].exp_err));
      tick();
      chk($sformatf("rej%0d_done_clr", i), int'(bus.done_o), 0);
      chk($sformatf("rej%0d_idle", i), int'(bus.req_ready_o), 1);
      chk($sformatf("rej%0d_no_psel", i), psel_cnt - base, 0);
    end

    // Read len=3 with a 5-cycle consumer stall on the second byte
    status_val = 8'h08;
    base = log_n;
    send_req(1'b1, 7'h3C, 8'd3, 8'd2);
    for (int k = 0; k < 3; k++) begin
      int t;
      t = 0;
      while (!bus.rdata_valid_o && t < 300) begin
        tick();
        t++;
      end
      chk($sformatf("rd_byte%0d", k), int'(bus.rdata_o), int'(rx_mem[k]));
      if (k == 1) begin
        repeat (5) tick();
        chk("rd_stall_valid", int'(bus.rdata_valid_o), 1);
        chk("rd_stall_data", int'(bus.rdata_o), 8'h22);
      end
      bus.rdata_ready_i = 1'b1;
      tick();
      bus.rdata_ready_i = 1'b0;
    end
    wait_done("rd");
    chk("rd_err", int'(bus.error_o), 0);
    tick();
    chk("rd_no_stall_apb", stall_err, 0);
    chk("rd_count", log_n - base, 11);
    chk("rd_addr_rw", int'(log_d[base + 2]), 8'h79);
    nstat = 0;
    nrecv = 0;
    for (int i = base; i < log_n; i++) begin
      if (!log_w[i] && log_a[i] == 8'h05) nstat++;
      if (!log_w[i] && log_a[i] == 8'h03) nrecv++;
    end
    chk("rd_status_reads", nstat, 3);
    chk("rd_receive_reads", nrecv, 3);
    chk("rd_close", {23'd0, log_w[log_n - 1], log_a[log_n - 1], log_d[log_n - 1]}, 32'h10120);

    // Read timeout: STATUS never shows RX data
    status_val = 8'h00;
    base = log_n;
    send_req(1'b1, 7'h10, 8'd1, 8'd3);
    wait_done("to");
    chk("to_err", int'(bus.error_o), 1);
    tick();
    chk("to_idle", int'(bus.req_ready_o), 1);
    chk("to_count", log_n - base, 9);
    nstat = 0;
    for (int i = base; i < log_n; i++)
      if (!log_w[i] && log_a[i] == 8'h05) nstat++;
    chk("to_status_reads", nstat, 4);
    chk("to_abort_cmd", {23'd0, log_w[log_n - 1], log_a[log_n - 1], log_d[log_n - 1]}, 32'h10100);

    // Same write with 3 wait states per transfer
    status_val = 8'h20;
    wait_cfg = 3;
    run_write_trace("wr3");
    chk("wr3_stable", stab_err, 0);
    wait_cfg = 0;

    // Reset in the middle of PUSH (len=8 is the largest accepted write)
    send_req(1'b0, 7'h22, 8'd8, 8'd1);
    chk("rp_busy", int'(bus.busy_o), 1);
    chk("rp_not_done", int'(bus.done_o), 0);
    feed_bytes(1, 8'hD0);
    bus.wdata_valid_i = 1'b1;
    bus.wdata_i = 8'hD1;
    for (int t = 0; t < 20 && !bus.m_psel_o; t++) tick();
    chk("rp_psel_before", int'(bus.m_psel_o), 1);
    rst = 1'b1;
    #1;
    chk("rp_psel", int'(bus.m_psel_o), 0);
    chk("rp_penable", int'(bus.m_penable_o), 0);
    chk("rp_busy_clr", int'(bus.busy_o), 0);
    chk("rp_req_ready", int'(bus.req_ready_o), 1);
    tick();
    rst = 1'b0;
    bus.wdata_valid_i = 1'b0;
    tick();
    base = log_n;
    send_req(1'b0, 7'h22, 8'd1, 8'd3);
    feed_bytes(1, 8'hC5);
    wait_done("rp2");
    chk("rp2_err", int'(bus.error_o), 0);
    tick();
    chk("rp2_count", log_n - base, 7);
    chk("rp2_first_cmd", {23'd0, log_w[base], log_a[base], log_d[base]}, 32'h10100);
    chk("rp2_byte", int'(log_d[base + 3]), 8'hC5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
